nexys_starship_shooter: RTL and testbench
=========================================

# nexys_starship_shooter

Player-side responder for the four monster state machines (top, bottom, left, right) in Nexys Starship. Each cycle it returns every monster's presence flag as `*_monster_ctrl`, forcing a flag low when the player shoots that monster. It also tracks aim direction, enforces a fire cooldown and keeps the score. It aggregates the per-monster game-over flags into a single held `gameover_ctrl` that is fed back to all monsters.

## Interface
Parameters:
- COOLDOWN_TICKS, 3: timer_tick pulses after a shot before the next shot is accepted (1..15).
- SCORE_MAX, 255: score saturation value (must fit in 8 bits).

Ports:
- Clk  in  1  system clock; one clock; reset is synchronous and active-high.
- Reset  in  1  synchronous, active-high; sampled on posedge Clk.
- timer_tick  in  1  single-Clk-cycle game-time pulse (same rate as the monster timers).
- play_flag  in  1  game start request from the home screen.
- BtnU, BtnD, BtnL, BtnR, BtnC  in  1 each  debounced single-cycle pulses: aim up/down/left/right, fire.
- top_monster_sm, btm_monster_sm, left_monster_sm, right_monster_sm  in  1 each  monster present.
- top_gameover, btm_gameover, left_gameover, right_gameover  in  1 each  monster timeout flags.
- top_monster_ctrl, btm_monster_ctrl, left_monster_ctrl, right_monster_ctrl  out  1 each  registered presence return.
- gameover_ctrl  out  1  held game-over broadcast.
- aim  out  2  00 top, 01 bottom, 10 left, 11 right.
- score  out  8  hits, saturating.
- shot_pulse, hit_pulse  out  1 each  one-cycle strobes for the display/sound.
- q_Idle, q_Play, q_Over  out  1 each  one-hot state.

## Operation
- States: IDLE, PLAY, OVER. The one-hot state is exported as {q_Over, q_Play, q_Idle}.
- IDLE:
  - Score and cooldown are cleared; aim is set to 00.
  - All ctrl outputs are 0; buttons are ignored.
  - Moves to PLAY when play_flag = 1.
- PLAY:
  - Each cycle, x_monster_ctrl <= x_monster_sm, except for a killed monster, whose ctrl is forced to 0.
  - Aim: BtnU→00, BtnD→01, BtnL→10, BtnR→11. If several pulse together, priority is U > D > L > R.
  - Fire is accepted when BtnC = 1 and cooldown = 0. An accepted fire:
    - pulses shot_pulse;
    - loads cooldown with COOLDOWN_TICKS;
    - if the monster at the current registered aim has sm = 1, kills it: its ctrl goes to 0, hit_pulse fires, and score increments, saturating at SCORE_MAX.
  - Fire with cooldown ≠ 0 is ignored: no pulse and no reload.
  - The cooldown counter (4-bit) decrements on each timer_tick while nonzero and never wraps below 0.
  - Any *_gameover = 1 moves the block to OVER.
- OVER:
  - gameover_ctrl = 1 and all ctrl outputs are 0.
  - Score is frozen; aim and fire are ignored.
  - BtnC returns the block to IDLE, and gameover_ctrl drops in that same transition.
- Simultaneous events:
  - Aim change and fire in the same cycle: the shot uses the aim held before the update. The new aim is visible the next cycle.
  - Game over and fire in the same cycle: game over wins. There is no kill, no score change and no shot_pulse.
  - Kill aimed at a monster whose sm rises in that same cycle: the kill counts, because sm is sampled.
- Reset, at any time including mid-cooldown or in OVER:
  - state IDLE, score 0, cooldown 0, aim 00;
  - all ctrl outputs, gameover_ctrl, shot_pulse and hit_pulse are 0.

## Timing
- All outputs are registered and update on posedge Clk.
- Reset takes effect at the first posedge with Reset = 1.
- Presence echo: a monster's sm sampled at edge n appears on its ctrl at edge n+1.
- Kill, with BtnC sampled at edge n:
  - ctrl = 0, hit_pulse = 1 and score+1 at edge n+1;
  - the monster's sm falls at its own edge n+2;
  - ctrl stays 0 thereafter because it echoes the now-0 sm.
- Cooldown: with BtnC accepted at edge n, the next fire is accepted once COOLDOWN_TICKS timer_tick pulses have been sampled after edge n.
- Game over: a *_gameover sampled at edge n sets gameover_ctrl = 1 and q_Over at edge n+1.
- Pulses are exactly one Clk cycle wide.

## Test plan
- Reset, then play_flag = 1 for one cycle → q_Play = 1 next cycle; score 0, aim 00, all ctrl 0.
- btm_monster_sm = 1 held; BtnD, then two cycles later BtnC → btm_monster_ctrl echoes 1, then drops to 0 on the edge after BtnC; hit_pulse = 1 for one cycle; score = 1.
- BtnC with aim 10 and left_monster_sm = 0 → shot_pulse = 1, hit_pulse = 0, score unchanged. A second BtnC before 3 timer_ticks → no shot_pulse. BtnC after the 3rd tick → shot_pulse = 1.
- BtnU and BtnR in the same cycle as BtnC, with aim 01 and btm_monster_sm = 1 → bottom monster killed; aim = 00 the next cycle.
- Score at 255 plus another hit → score stays 255, hit_pulse still 1.
- right_gameover = 1 in the same cycle as an accepted kill → gameover_ctrl = 1, no score change. BtnC → IDLE with gameover_ctrl = 0. Reset asserted mid-cooldown in PLAY → all outputs reach their reset values after one edge.

Source files
------------

// File: rtl/nexys_starship_shooter.sv
// Player-side responder for the four Nexys Starship monsters.
// Echoes presence, handles aim/fire/cooldown/score and game over.
module nexys_starship_shooter #(
    parameter int COOLDOWN_TICKS = 3,
    parameter int SCORE_MAX      = 255
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       timer_tick,
    input  logic       play_flag,
    input  logic       BtnU,
    input  logic       BtnD,
    input  logic       BtnL,
    input  logic       BtnR,
    input  logic       BtnC,
    input  logic       top_monster_sm,
    input  logic       btm_monster_sm,
    input  logic       left_monster_sm,
    input  logic       right_monster_sm,
    input  logic       top_gameover,
    input  logic       btm_gameover,
    input  logic       left_gameover,
    input  logic       right_gameover,
    output logic       top_monster_ctrl,
    output logic       btm_monster_ctrl,
    output logic       left_monster_ctrl,
    output logic       right_monster_ctrl,
    output logic       gameover_ctrl,
    output logic [1:0] aim,
    output logic [7:0] score,
    output logic       shot_pulse,
    output logic       hit_pulse,
    output logic       q_Idle,
    output logic       q_Play,
    output logic       q_Over
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    localparam logic [3:0] CD_LOAD = 4'(COOLDOWN_TICKS);
    localparam logic [7:0] S_MAX   = 8'(SCORE_MAX);

    state_t     state;
    state_t     next_state;
    logic [3:0] cooldown;
    logic [3:0] ctrl;
    logic [3:0] sm;
    logic [3:0] kill;
    logic       any_go;
    logic       live;
    logic       fire;
    logic       hit;
    logic       clear;

    // Bit index matches the aim encoding: 0 top, 1 bottom, 2 left, 3 right.
    assign sm     = {right_monster_sm, left_monster_sm,
                     btm_monster_sm, top_monster_sm};
    assign any_go = top_gameover | btm_gameover |
                    left_gameover | right_gameover;
    assign live   = (state == PLAY) && !any_go;
    assign fire   = live && BtnC && (cooldown == 4'd0);
    assign hit    = fire && sm[aim];
    assign kill   = hit ? (4'b0001 << aim) : 4'b0000;
    assign clear  = (state == IDLE) || ((state == OVER) && BtnC);

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (play_flag) next_state = PLAY;
            PLAY:    if (any_go)    next_state = OVER;
            OVER:    if (BtnC)      next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        q_Idle = (state == IDLE);
        q_Play = (state == PLAY);
        q_Over = (state == OVER);
    end

    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            ctrl          <= 4'd0;
            gameover_ctrl <= 1'b0;
            aim           <= 2'b00;
            score         <= 8'd0;
            cooldown      <= 4'd0;
            shot_pulse    <= 1'b0;
            hit_pulse     <= 1'b0;
        end else begin
            shot_pulse    <= fire;
            hit_pulse     <= hit;
            ctrl          <= live ? (sm & ~kill) : 4'd0;
            gameover_ctrl <= (state == OVER) || any_go;
            if (fire)
                cooldown <= CD_LOAD;
            else if (timer_tick && cooldown != 4'd0)
                cooldown <= cooldown - 4'd1;
            if (hit && score < S_MAX)
                score <= score + 8'd1;
            // Aim updates after the shot has used the old value.
            if (live) begin
                priority case (1'b1)
                    BtnU:    aim <= 2'b00;
                    BtnD:    aim <= 2'b01;
                    BtnL:    aim <= 2'b10;
                    BtnR:    aim <= 2'b11;
                    default: aim <= aim;
                endcase
            end
        end
    end

    assign top_monster_ctrl   = ctrl[0];
    assign btm_monster_ctrl   = ctrl[1];
    assign left_monster_ctrl  = ctrl[2];
    assign right_monster_ctrl = ctrl[3];

endmodule

// File: tb/tb_nexys_starship_shooter.sv
// Scoreboard bench for nexys_starship_shooter.
// Expected outputs are queued per cycle and compared after each edge.
module tb_nexys_starship_shooter;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       timer_tick = 1'b0, play_flag = 1'b0;
    logic       BtnU = 1'b0, BtnD = 1'b0, BtnL = 1'b0, BtnR = 1'b0, BtnC = 1'b0;
    logic       top_sm = 1'b0, btm_sm = 1'b0, left_sm = 1'b0, right_sm = 1'b0;
    logic       top_go = 1'b0, btm_go = 1'b0, left_go = 1'b0, right_go = 1'b0;
    logic       top_ctrl, btm_ctrl, left_ctrl, right_ctrl;
    logic       gameover_ctrl, shot_pulse, hit_pulse;
    logic       q_Idle, q_Play, q_Over;
    logic [1:0] aim;
    logic [7:0] score;

    always #5 Clk = ~Clk;

    nexys_starship_shooter dut (
        .Clk(Clk), .Reset(Reset), .timer_tick(timer_tick),
        .play_flag(play_flag),
        .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR), .BtnC(BtnC),
        .top_monster_sm(top_sm), .btm_monster_sm(btm_sm),
        .left_monster_sm(left_sm), .right_monster_sm(right_sm),
        .top_gameover(top_go), .btm_gameover(btm_go),
        .left_gameover(left_go), .right_gameover(right_go),
        .top_monster_ctrl(top_ctrl), .btm_monster_ctrl(btm_ctrl),
        .left_monster_ctrl(left_ctrl), .right_monster_ctrl(right_ctrl),
        .gameover_ctrl(gameover_ctrl), .aim(aim), .score(score),
        .shot_pulse(shot_pulse), .hit_pulse(hit_pulse),
        .q_Idle(q_Idle), .q_Play(q_Play), .q_Over(q_Over)
    );

    // btn = {U,D,L,R,C}; sm/go/ctrl = {top,btm,left,right}
    typedef struct packed {
        logic       rst;
        logic       play;
        logic [4:0] btn;
        logic [3:0] sm;
        logic [3:0] go;
        logic       tick;
    } stim_t;

    typedef struct packed {
        logic [3:0] ctrl;
        logic       go;
        logic [1:0] aim;
        logic [7:0] score;
        logic       shot;
        logic       hit;
        logic [2:0] q;
    } out_t;

    localparam logic [2:0] QI = 3'b001;
    localparam logic [2:0] QP = 3'b010;
    localparam logic [2:0] QO = 3'b100;
    localparam logic [4:0] B0 = 5'b00000;
    localparam logic [4:0] BU = 5'b10000;
    localparam logic [4:0] BD = 5'b01000;
    localparam logic [4:0] BL = 5'b00100;
    localparam logic [4:0] BR = 5'b00010;
    localparam logic [4:0] BC = 5'b00001;

    out_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic stim_t st(logic rst, logic play, logic [4:0] btn,
                                 logic [3:0] s, logic [3:0] g, logic tick);
        st = '{rst, play, btn, s, g, tick};
    endfunction

    function automatic out_t ex(logic [3:0] c, logic g, logic [1:0] a,
                                logic [7:0] sc, logic sh, logic h,
                                logic [2:0] q);
        ex = '{c, g, a, sc, sh, h, q};
    endfunction

    function automatic out_t sample();
        sample = '{{top_ctrl, btm_ctrl, left_ctrl, right_ctrl},
                   gameover_ctrl, aim, score, shot_pulse, hit_pulse,
                   {q_Over, q_Play, q_Idle}};
    endfunction

    task automatic drive(input stim_t s);
        Reset      = s.rst;
        play_flag  = s.play;
        {BtnU, BtnD, BtnL, BtnR, BtnC} = s.btn;
        {top_sm, btm_sm, left_sm, right_sm} = s.sm;
        {top_go, btm_go, left_go, right_go} = s.go;
        timer_tick = s.tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t s[$];
        out_t  e[$];
        out_t  got, want;
        s.push_back(st(1, 0, B0, 4'h0, 4'h0, 0));
        e.push_back(ex(4'h0, 0, 2'b00, 8'd0, 0, 0, QI));
        s.push_back(st(0, 0, 5'b11111, 4'hF, 4'h0, 1));
        e.push_back(ex(4'h0, 0, 2'b00, 8'd0, 0, 0, QI));
        s.push_back(st(0, 1, B0, 4'h0, 4'h0, 0));
        e.push_back(ex(4'h0, 0, 2'b00, 8'd0, 0, 0, QP));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(e[i]);
            drive(s[i]);
            got = sample();
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset[%0d] got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_kill();
        stim_t s[$];
        out_t  e[$];
        out_t  got, want;
        s.push_back(st(0, 0, BD, 4'b0100, 4'h0, 0));
        e.push_back(ex(4'b0100, 0, 2'b01, 8'd0, 0, 0, QP));
        s.push_back(st(0, 0, B0, 4'b0100, 4'h0, 0));
        e.push_back(ex(4'b0100, 0, 2'b01, 8'd0, 0, 0, QP));
        s.push_back(st(0, 0, BC, 4'b0100, 4'h0, 0));
        e.push_back(ex(4'b0000, 0, 2'b01, 8'd1, 1, 1, QP));
        s.push_back(st(0, 0, B0, 4'b0000, 4'h0, 0));
        e.push_back(ex(4'b0000, 0, 2'b01, 8'd1, 0, 0, QP));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(e[i]);
            drive(s[i]);
            got = sample();
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL kill[%0d] got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_cooldown();
        stim_t s[$];
        out_t  e[$];
        out_t  got, want;
        out_t  idle_o, shot_o;
        idle_o = ex(4'h0, 0, 2'b10, 8'd1, 0, 0, QP);
        shot_o = ex(4'h0, 0, 2'b10, 8'd1, 1, 0, QP);
        s.push_back(st(0, 0, BL, 4'h0, 4'h0, 0)); e.push_back(idle_o);
        repeat (3) begin
            s.push_back(st(0, 0, B0, 4'h0, 4'h0, 1)); e.push_back(idle_o);
        end
        // Miss: left absent, others present and echoed.
        s.push_back(st(0, 0, BC, 4'b1100, 4'h0, 0));
        e.push_back(ex(4'b1100, 0, 2'b10, 8'd1, 1, 0, QP));
        s.push_back(st(0, 0, B0, 4'h0, 4'h0, 1)); e.push_back(idle_o);
        s.push_back(st(0, 0, BC, 4'h0, 4'h0, 0)); e.push_back(idle_o);
        repeat (2) begin
            s.push_back(st(0, 0, B0, 4'h0, 4'h0, 1)); e.push_back(idle_o);
        end
        s.push_back(st(0, 0, BC, 4'h0, 4'h0, 0)); e.push_back(shot_o);
        repeat (4) begin
            s.push_back(st(0, 0, B0, 4'h0, 4'h0, 1)); e.push_back(idle_o);
        end
        s.push_back(st(0, 0, BC, 4'h0, 4'h0, 0)); e.push_back(shot_o);
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(e[i]);
            drive(s[i]);
            got = sample();
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL cooldown[%0d] got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t s[$];
        out_t  e[$];
        out_t  got, want;
        s.push_back(st(0, 0, BD, 4'b0100, 4'h0, 1));
        e.push_back(ex(4'b0100, 0, 2'b01, 8'd1, 0, 0, QP));
        repeat (2) begin
            s.push_back(st(0, 0, B0, 4'b0100, 4'h0, 1));
            e.push_back(ex(4'b0100, 0, 2'b01, 8'd1, 0, 0, QP));
        end
        s.push_back(st(0, 0, BU | BR | BC, 4'b0100, 4'h0, 0));
        e.push_back(ex(4'b0000, 0, 2'b00, 8'd2, 1, 1, QP));
        s.push_back(st(0, 0, B0, 4'b0000, 4'h0, 0));
        e.push_back(ex(4'b0000, 0, 2'b00, 8'd2, 0, 0, QP));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(e[i]);
            drive(s[i]);
            got = sample();
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL b2b[%0d] got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_gameover();
        stim_t s[$];
        out_t  e[$];
        out_t  got, want;
        s.push_back(st(0, 0, BR, 4'h0, 4'h0, 1));
        e.push_back(ex(4'h0, 0, 2'b11, 8'd2, 0, 0, QP));
        repeat (2) begin
            s.push_back(st(0, 0, B0, 4'h0, 4'h0, 1));
            e.push_back(ex(4'h0, 0, 2'b11, 8'd2, 0, 0, QP));
        end
        s.push_back(st(0, 0, BC, 4'b0001, 4'b0001, 0));
        e.push_back(ex(4'h0, 1, 2'b11, 8'd2, 0, 0, QO));
        s.push_back(st(0, 0, BU, 4'hF, 4'h0, 0));
        e.push_back(ex(4'h0, 1, 2'b11, 8'd2, 0, 0, QO));
        s.push_back(st(0, 0, BC, 4'h0, 4'h0, 0));
        e.push_back(ex(4'h0, 0, 2'b00, 8'd0, 0, 0, QI));
        s.push_back(st(0, 1, B0, 4'h0, 4'h0, 0));
        e.push_back(ex(4'h0, 0, 2'b00, 8'd0, 0, 0, QP));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(e[i]);
            drive(s[i]);
            got = sample();
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL gameover[%0d] got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_saturate();
        out_t got, want;
        int   sc = 0;
        for (int i = 0; i < 256; i++) begin
            // Top monster rises in the same cycle as the shot.
            sc = (sc < 255) ? sc + 1 : 255;
            for (int k = 0; k < 4; k++) begin
                if (k == 0)
                    sb.push_back(ex(4'h0, 0, 2'b00, 8'(sc), 1, 1, QP));
                else
                    sb.push_back(ex(4'h0, 0, 2'b00, 8'(sc), 0, 0, QP));
                drive(k == 0 ? st(0, 0, BC, 4'b1000, 4'h0, 0)
                             : st(0, 0, B0, 4'h0, 4'h0, 1));
                got = sample();
                want = sb.pop_front();
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL saturate[%0d.%0d] got %h want %h",
                             i, k, got, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t s[$];
        out_t  e[$];
        out_t  got, want;
        s.push_back(st(0, 0, BC, 4'h0, 4'h0, 0));
        e.push_back(ex(4'h0, 0, 2'b00, 8'd255, 1, 0, QP));
        s.push_back(st(0, 0, B0, 4'h0, 4'h0, 1));
        e.push_back(ex(4'h0, 0, 2'b00, 8'd255, 0, 0, QP));
        s.push_back(st(1, 0, BC, 4'hF, 4'h0, 0));
        e.push_back(ex(4'h0, 0, 2'b00, 8'd0, 0, 0, QI));
        s.push_back(st(0, 1, B0, 4'h0, 4'h0, 0));
        e.push_back(ex(4'h0, 0, 2'b00, 8'd0, 0, 0, QP));
        s.push_back(st(0, 0, BC, 4'b1000, 4'h0, 0));
        e.push_back(ex(4'h0, 0, 2'b00, 8'd1, 1, 1, QP));
        for (int i = 0; i < s.size(); i++) begin
            sb.push_back(e[i]);
            drive(s[i]);
            got = sample();
            want = sb.pop_front();
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL reset_mid[%0d] got %h want %h", i, got, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_kill();
        test_cooldown();
        test_back_to_back();
        test_gameover();
        test_saturate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
